// File: rtl/ds18b20_temp_monitor.sv
// ds18b20_temp_monitor: schedules DS18B20 exchanges and filters the returned temperature
// Ports: CLK_10MHZ clock, nRESET async active-low reset, startExch ack from controller,
//        presenseIn/temperatureIn controller results, start request pulse, tempAvg 4-sample
//        signed average, tempValid average valid, overTemp alarm with hysteresis,
//        sensorFault consecutive-failure flag, sampleStrobe pulse after every evaluation.
// Option: define DS18B20_FAULT_FAILSAFE_EN to force overTemp high while sensorFault is set.
module ds18b20_temp_monitor #(
  parameter int CLK_HZ     = 10000000,
  parameter int PERIOD_MS  = 1000,
  parameter int ACK_TO_CYC = 1000,
  parameter int SETTLE_MS  = 20,
  parameter int HI_THR     = 60,
  parameter int HYST       = 5,
  parameter int FAIL_LIMIT = 3
) (
  input  logic       CLK_10MHZ,
  input  logic       nRESET,
  input  logic       startExch,
  input  logic       presenseIn,
  input  logic [7:0] temperatureIn,
  output logic       start,
  output logic [7:0] tempAvg,
  output logic       tempValid,
  output logic       overTemp,
  output logic       sensorFault,
  output logic       sampleStrobe
);
  localparam int TICK_CYC = CLK_HZ / 1000;
  localparam logic signed [7:0] SET_THR = 8'(HI_THR);
  localparam logic signed [7:0] CLR_THR = 8'(HI_THR - HYST);
`ifdef DS18B20_FAULT_FAILSAFE_EN
  localparam bit FAILSAFE = 1'b1;
`else
  localparam bit FAILSAFE = 1'b0;
`endif
  typedef enum logic [1:0] {WAIT, REQ, SETTLE, EVAL} stateT;
  stateT state;
  logic [31:0] preCnt, periodCnt, ackCnt, settleCnt;
  logic ackOk, primed, firstSample;
  logic [3:0] failCnt, failNext;
  // only the three most recent samples are stored; the fourth is always the incoming one
  logic [7:0] slot [3];
  logic signed [7:0] newAvg;
  logic tick, sampleOk, discard;
  function automatic logic [9:0] sx(input logic [7:0] v);
    return {{2{v[7]}}, v};
  endfunction
  always_comb begin
    tick = preCnt == 32'(TICK_CYC - 1);
    sampleOk = ackOk && presenseIn && temperatureIn != 8'h80;
    discard = firstSample && temperatureIn == 8'h55;
    failNext = failCnt == 4'd15 ? 4'd15 : failCnt + 4'd1;
    // bits [9:2] of the two's-complement sum are the floor of sum/4
    newAvg = 8'((sx(temperatureIn) + sx(primed ? slot[0] : temperatureIn)
               + sx(primed ? slot[1] : temperatureIn) + sx(primed ? slot[2] : temperatureIn)) >> 2);
  end
  always_ff @(posedge CLK_10MHZ or negedge nRESET) begin
    if (!nRESET) begin
      state <= WAIT;
      preCnt <= '0;
      periodCnt <= 32'(PERIOD_MS - 1);
      ackCnt <= '0;
      settleCnt <= '0;
      ackOk <= 1'b0;
      primed <= 1'b0;
      firstSample <= 1'b1;
      failCnt <= '0;
      slot <= '{default: '0};
      start <= 1'b0;
      tempAvg <= '0;
      tempValid <= 1'b0;
      overTemp <= 1'b0;
      sensorFault <= 1'b0;
      sampleStrobe <= 1'b0;
    end else begin
      start <= 1'b0;
      sampleStrobe <= 1'b0;
      preCnt <= tick ? '0 : preCnt + 32'd1;
      // counts ticks since the last start in every state so the period is start-to-start
      if (tick && periodCnt != 32'(PERIOD_MS - 1)) periodCnt <= periodCnt + 32'd1;
      case (state)
        WAIT: if (tick && periodCnt == 32'(PERIOD_MS - 1)) begin
          state <= REQ;
          start <= 1'b1;
          periodCnt <= '0;
          ackCnt <= '0;
          ackOk <= 1'b0;
        end
        REQ: if (startExch) begin
          state <= SETTLE;
          ackOk <= 1'b1;
          settleCnt <= '0;
        end else if (ackCnt == 32'(ACK_TO_CYC - 1)) state <= EVAL;
        else ackCnt <= ackCnt + 32'd1;
        SETTLE: if (tick) begin
          if (settleCnt == 32'(SETTLE_MS - 1)) state <= EVAL;
          else settleCnt <= settleCnt + 32'd1;
        end
        EVAL: begin
          state <= WAIT;
          sampleStrobe <= 1'b1;
          if (sampleOk) begin
            firstSample <= 1'b0;
            // a leading +85 is the power-on scratchpad value, not a reading
            if (!discard) begin
              failCnt <= '0;
              sensorFault <= 1'b0;
              primed <= 1'b1;
              slot[0] <= temperatureIn;
              slot[1] <= primed ? slot[0] : temperatureIn;
              slot[2] <= primed ? slot[1] : temperatureIn;
              tempAvg <= newAvg;
              tempValid <= 1'b1;
              overTemp <= newAvg >= SET_THR ? 1'b1 : newAvg <= CLR_THR ? 1'b0 : overTemp;
            end
          end else begin
            failCnt <= failNext;
            if (failNext >= 4'(FAIL_LIMIT)) begin
              sensorFault <= 1'b1;
              tempValid <= 1'b0;
              primed <= 1'b0;
              if (FAILSAFE) overTemp <= 1'b1;
            end
          end
        end
        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ds18b20_temp_monitor.sv
// tb_ds18b20_temp_monitor: randomized and directed checks of ds18b20_temp_monitor against a behavioural model
module tb_ds18b20_temp_monitor;
  localparam int CLK_HZ = 10000;
  localparam int TICK = CLK_HZ / 1000;
  localparam int PERIOD_MS = 40;
  localparam int ACK_TO = 30;
  localparam int SETTLE_MS = 5;
  localparam int HI = 60;
  localparam int HY = 5;
  localparam int FL = 3;
  logic CLK_10MHZ = 1'b0;
  logic nRESET = 1'b0;
  logic startExch = 1'b0;
  logic presenseIn = 1'b0;
  logic [7:0] temperatureIn = 8'h00;
  logic start, tempValid, overTemp, sensorFault, sampleStrobe;
  logic [7:0] tempAvg;
  ds18b20_temp_monitor #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .ACK_TO_CYC(ACK_TO), .SETTLE_MS(SETTLE_MS),
    .HI_THR(HI), .HYST(HY), .FAIL_LIMIT(FL)
  ) dut (
    .CLK_10MHZ(CLK_10MHZ), .nRESET(nRESET), .startExch(startExch), .presenseIn(presenseIn),
    .temperatureIn(temperatureIn), .start(start), .tempAvg(tempAvg), .tempValid(tempValid),
    .overTemp(overTemp), .sensorFault(sensorFault), .sampleStrobe(sampleStrobe)
  );
  always #50 CLK_10MHZ = ~CLK_10MHZ;
  int cyc = 0;
  always @(posedge CLK_10MHZ) cyc <= cyc + 1;
  int total = 0, bad = 0, lastStart = -1, relCyc = 0;
  int hist[$];
  bit mPrimed, mFirst, mValid, mOt, mFault;
  int mFail, mAvg;
  typedef struct packed {bit rst; bit ack; bit pres; logic [7:0] t;} stepT;
  stepT dirSeq [23] = '{
    '{1'b0, 1'b1, 1'b1, 8'h19},
    '{1'b1, 1'b1, 1'b1, 8'h55}, '{1'b0, 1'b1, 1'b1, 8'h14},
    '{1'b1, 1'b1, 1'b1, 8'h3A}, '{1'b0, 1'b1, 1'b1, 8'h3C}, '{1'b0, 1'b1, 1'b1, 8'h3E},
    '{1'b0, 1'b1, 1'b1, 8'h40}, '{1'b0, 1'b1, 1'b1, 8'h34}, '{1'b0, 1'b1, 1'b1, 8'h34},
    '{1'b0, 1'b1, 1'b1, 8'h34}, '{1'b0, 1'b1, 1'b1, 8'h34},
    '{1'b1, 1'b1, 1'b1, 8'hFF}, '{1'b0, 1'b1, 1'b1, 8'hFE}, '{1'b0, 1'b1, 1'b1, 8'hFE},
    '{1'b0, 1'b1, 1'b1, 8'hFE},
    '{1'b1, 1'b1, 1'b1, 8'h3A}, '{1'b0, 1'b0, 1'b1, 8'h3A}, '{1'b0, 1'b0, 1'b1, 8'h3A},
    '{1'b0, 1'b0, 1'b1, 8'h3A}, '{1'b0, 1'b1, 1'b1, 8'h10},
    '{1'b0, 1'b1, 1'b0, 8'h20}, '{1'b0, 1'b1, 1'b1, 8'h80}, '{1'b0, 1'b1, 1'b1, 8'h22}
  };

  task automatic model_reset();
    hist.delete();
    mPrimed = 0; mFirst = 1; mValid = 0; mOt = 0; mFault = 0; mFail = 0; mAvg = 0;
  endtask

  task automatic model_step(input bit ok, input logic [7:0] t);
    int tv, s;
    tv = int'($signed(t));
    if (ok && mFirst && t == 8'h55) mFirst = 0;
    else if (ok) begin
      mFirst = 0; mFail = 0; mFault = 0;
      if (!mPrimed) hist = '{tv, tv, tv, tv};
      else begin
        hist.push_back(tv);
        void'(hist.pop_front());
      end
      mPrimed = 1;
      s = 0;
      foreach (hist[i]) s += hist[i];
      mAvg = s >= 0 ? s / 4 : -((-s + 3) / 4);
      mValid = 1;
      if (mAvg >= HI) mOt = 1;
      else if (mAvg <= HI - HY) mOt = 0;
    end else begin
      if (mFail < 15) mFail++;
      if (mFail >= FL) begin
        mFault = 1; mValid = 0; mPrimed = 0;
`ifdef DS18B20_FAULT_FAILSAFE_EN
        mOt = 1;
`endif
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK_10MHZ);
    nRESET = 1'b0;
    startExch = 1'b0;
    repeat (3) @(negedge CLK_10MHZ);
    nRESET = 1'b1;
    relCyc = cyc;
    lastStart = -1;
    model_reset();
  endtask

  // plays the controller for one exchange; reports start gap, strobe latency and stray pulses
  task automatic do_sample(input bit ack, input bit pres, input logic [7:0] t, input bit spur,
                           output int gap, output int lat, output bit stray, output bit wide);
    int n;
    bit got;
    got = 0; stray = 0; wide = 0; gap = -1; lat = -1;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge CLK_10MHZ);
      if (sampleStrobe) stray = 1;
      if (start) got = 1;
      else if (spur) startExch = ($urandom_range(0, 15) == 0);
    end
    startExch = 1'b0;
    if (!got) return;
    gap = lastStart < 0 ? cyc - relCyc : cyc - lastStart;
    lastStart = cyc;
    @(negedge CLK_10MHZ);
    if (start) wide = 1;
    presenseIn = pres;
    temperatureIn = t;
    n = 1;
    if (ack) begin
      repeat ($urandom_range(0, 4)) @(negedge CLK_10MHZ);
      startExch = 1'b1;
      n = 0;
    end
    while (n < 300) begin
      @(negedge CLK_10MHZ);
      n++;
      startExch = 1'b0;
      if (start) wide = 1;
      if (sampleStrobe) break;
    end
    lat = sampleStrobe ? n : -1;
  endtask

  task automatic test_reset();
    model_reset();
    nRESET = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK_10MHZ);
      startExch = 1'($urandom);
      presenseIn = 1'($urandom);
      temperatureIn = 8'($urandom);
      total++;
      if ({start, tempAvg, tempValid, overTemp, sensorFault, sampleStrobe} !== 13'd0) begin
        bad++;
        $display("FAIL reset[%0d] outputs got=%b exp=0", i, {start, tempAvg, tempValid, overTemp, sensorFault, sampleStrobe});
      end
    end
    @(negedge CLK_10MHZ);
    startExch = 1'b0;
    nRESET = 1'b1;
    relCyc = cyc;
    lastStart = -1;
  endtask

  task automatic test_directed();
    int gap, lat, expGap;
    bit stray, wide;
    stepT s;
    for (int i = 0; i < 23; i++) begin
      s = dirSeq[i];
      if (s.rst) do_reset();
      expGap = lastStart < 0 ? TICK : PERIOD_MS * TICK;
      do_sample(s.ack, s.pres, s.t, 1'b0, gap, lat, stray, wide);
      model_step(s.ack && s.pres && s.t != 8'h80, s.t);
      total++;
      if (gap !== expGap) begin bad++; $display("FAIL directed[%0d] start_gap got=%0d exp=%0d", i, gap, expGap); end
      total++;
      if (s.ack ? (lat < (SETTLE_MS - 1) * TICK + 2 || lat > SETTLE_MS * TICK + 1) : lat != ACK_TO + 1) begin
        bad++; $display("FAIL directed[%0d] strobe_latency got=%0d ack=%0d", i, lat, s.ack);
      end
      total++;
      if (stray || wide) begin bad++; $display("FAIL directed[%0d] pulse_width stray=%0d wide=%0d exp=0", i, stray, wide); end
      total++;
      if (tempAvg !== 8'(mAvg)) begin bad++; $display("FAIL directed[%0d] tempAvg got=%0d exp=%0d", i, $signed(tempAvg), mAvg); end
      total++;
      if (tempValid !== mValid) begin bad++; $display("FAIL directed[%0d] tempValid got=%0d exp=%0d", i, tempValid, mValid); end
      total++;
      if (overTemp !== mOt) begin bad++; $display("FAIL directed[%0d] overTemp got=%0d exp=%0d", i, overTemp, mOt); end
      total++;
      if (sensorFault !== mFault) begin bad++; $display("FAIL directed[%0d] sensorFault got=%0d exp=%0d", i, sensorFault, mFault); end
    end
  endtask

  task automatic test_reset_mid();
    int gap, lat;
    bit got, stray, wide;
    got = 0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge CLK_10MHZ);
      got = start;
    end
    total++;
    if (!got) begin bad++; $display("FAIL reset_mid start got=0 exp=1"); end
    repeat (2) @(negedge CLK_10MHZ);
    startExch = 1'b1;
    presenseIn = 1'b1;
    temperatureIn = 8'h30;
    @(negedge CLK_10MHZ);
    startExch = 1'b0;
    repeat (15) @(negedge CLK_10MHZ);
    #20 nRESET = 1'b0;
    #1;
    total++;
    if ({start, tempAvg, tempValid, overTemp, sensorFault, sampleStrobe} !== 13'd0) begin
      bad++; $display("FAIL reset_mid async outputs got=%b exp=0", {start, tempAvg, tempValid, overTemp, sensorFault, sampleStrobe});
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK_10MHZ);
      total++;
      if (start || sampleStrobe) begin bad++; $display("FAIL reset_mid[%0d] pulse start=%0d strobe=%0d exp=0", i, start, sampleStrobe); end
    end
    nRESET = 1'b1;
    relCyc = cyc;
    lastStart = -1;
    model_reset();
    do_sample(1'b1, 1'b1, 8'h2A, 1'b0, gap, lat, stray, wide);
    model_step(1'b1, 8'h2A);
    total++;
    if (gap !== TICK) begin bad++; $display("FAIL reset_mid start_gap got=%0d exp=%0d", gap, TICK); end
    total++;
    if (stray || wide) begin bad++; $display("FAIL reset_mid pulse stray=%0d wide=%0d exp=0", stray, wide); end
    total++;
    if (tempAvg !== 8'(mAvg) || tempValid !== mValid) begin
      bad++; $display("FAIL reset_mid sample avg=%0d valid=%0d exp avg=%0d valid=%0d", $signed(tempAvg), tempValid, mAvg, mValid);
    end
  endtask

  task automatic test_random();
    int gap, lat, expGap, r;
    bit ack, pres, stray, wide;
    logic [7:0] t;
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 11) == 0) do_reset();
      ack = $urandom_range(0, 7) != 0;
      pres = $urandom_range(0, 7) != 0;
      r = $urandom_range(0, 9);
      t = r == 0 ? 8'h80 : r == 1 ? 8'h55 : r < 4 ? 8'($urandom) : 8'($urandom_range(40, 70));
      expGap = lastStart < 0 ? TICK : PERIOD_MS * TICK;
      do_sample(ack, pres, t, 1'b1, gap, lat, stray, wide);
      model_step(ack && pres && t != 8'h80, t);
      total++;
      if (gap !== expGap) begin bad++; $display("FAIL random[%0d] start_gap got=%0d exp=%0d", i, gap, expGap); end
      total++;
      if (ack ? (lat < (SETTLE_MS - 1) * TICK + 2 || lat > SETTLE_MS * TICK + 1) : lat != ACK_TO + 1) begin
        bad++; $display("FAIL random[%0d] strobe_latency got=%0d ack=%0d", i, lat, ack);
      end
      total++;
      if (stray || wide) begin bad++; $display("FAIL random[%0d] pulse_width stray=%0d wide=%0d exp=0", i, stray, wide); end
      total++;
      if (tempAvg !== 8'(mAvg) || tempValid !== mValid || overTemp !== mOt || sensorFault !== mFault) begin
        bad++;
        $display("FAIL random[%0d] outputs t=%h got avg=%0d v=%0d ot=%0d f=%0d exp avg=%0d v=%0d ot=%0d f=%0d",
                 i, t, $signed(tempAvg), tempValid, overTemp, sensorFault, mAvg, mValid, mOt, mFault);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
